// File: rtl/writeback_merge_arbiter_if.sv
// ============================================================================
// writeback_merge_arbiter_if : per-unit request bus and merged writeback port
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

interface writeback_merge_arbiter_if #(
    parameter int NUM_UNITS       = 4,
    parameter int REG_WIDTH       = 5,
    parameter int DATA_WIDTH      = 64,
    parameter int UNIT_CODE_WIDTH = 3
);
    logic [NUM_UNITS-1:0]                 valid_i;
    logic [NUM_UNITS-1:0]                 ready_o;
    logic [NUM_UNITS-1:0]                 overflow_o;
    logic [NUM_UNITS*UNIT_CODE_WIDTH-1:0] unitCode_i;
    logic [NUM_UNITS-1:0]                 reg1En_i;
    logic [NUM_UNITS-1:0]                 reg2En_i;
    logic [NUM_UNITS*REG_WIDTH-1:0]       reg1Addr_i;
    logic [NUM_UNITS*REG_WIDTH-1:0]       reg2Addr_i;
    logic [NUM_UNITS*DATA_WIDTH-1:0]      reg1Val_i;
    logic [NUM_UNITS*DATA_WIDTH-1:0]      reg2Val_i;
    logic                                 wbReady_i;
    logic                                 valid_o;
    logic [UNIT_CODE_WIDTH-1:0]           functionalUnitCode_o;
    logic                                 reg1WritebackEnable_o;
    logic                                 reg2WritebackEnable_o;
    logic [REG_WIDTH-1:0]                 reg1WritebackAddress_o;
    logic [REG_WIDTH-1:0]                 reg2WritebackAddress_o;
    logic [DATA_WIDTH-1:0]                reg1WritebackVal_o;
    logic [DATA_WIDTH-1:0]                reg2WritebackVal_o;

    modport slave (
        input  valid_i, unitCode_i, reg1En_i, reg2En_i, reg1Addr_i, reg2Addr_i,
               reg1Val_i, reg2Val_i, wbReady_i,
        output ready_o, overflow_o, valid_o, functionalUnitCode_o,
               reg1WritebackEnable_o, reg2WritebackEnable_o,
               reg1WritebackAddress_o, reg2WritebackAddress_o,
               reg1WritebackVal_o, reg2WritebackVal_o
    );

    modport master (
        output valid_i, unitCode_i, reg1En_i, reg2En_i, reg1Addr_i, reg2Addr_i,
               reg1Val_i, reg2Val_i, wbReady_i,
        input  ready_o, overflow_o, valid_o, functionalUnitCode_o,
               reg1WritebackEnable_o, reg2WritebackEnable_o,
               reg1WritebackAddress_o, reg2WritebackAddress_o,
               reg1WritebackVal_o, reg2WritebackVal_o
    );
endinterface

`default_nettype wire

// File: rtl/writeback_merge_arbiter.sv
// ============================================================================
// writeback_merge_arbiter : per-unit FIFOs merged round-robin onto one
// registered writeback port with backpressure and flush.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_merge_arbiter #(
    parameter int NUM_UNITS       = 4,
    parameter int DEPTH           = 4,
    parameter int REG_WIDTH       = 5,
    parameter int DATA_WIDTH      = 64,
    parameter int UNIT_CODE_WIDTH = 3
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    writeback_merge_arbiter_if.slave   wb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int UW    = $clog2(NUM_UNITS);

    typedef struct packed {
        logic [UNIT_CODE_WIDTH-1:0] code;
        logic                       en1;
        logic                       en2;
        logic [REG_WIDTH-1:0]       addr1;
        logic [REG_WIDTH-1:0]       addr2;
        logic [DATA_WIDTH-1:0]      val1;
        logic [DATA_WIDTH-1:0]      val2;
    } entry_t;

    typedef logic [UW:0] uext_t;

    entry_t               mem_q    [NUM_UNITS][DEPTH];
    entry_t               mem_d    [NUM_UNITS][DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q [NUM_UNITS];
    logic [PTR_W-1:0]     wr_ptr_d [NUM_UNITS];
    logic [PTR_W-1:0]     rd_ptr_q [NUM_UNITS];
    logic [PTR_W-1:0]     rd_ptr_d [NUM_UNITS];
    logic [CNT_W-1:0]     count_q  [NUM_UNITS];
    logic [CNT_W-1:0]     count_d  [NUM_UNITS];
    entry_t               in_entry [NUM_UNITS];
    logic [NUM_UNITS-1:0] overflow_q, overflow_d;
    logic [NUM_UNITS-1:0] not_full, push, pop;
    logic [UW-1:0]        rr_q, rr_d, grant, rr_after_grant;
    logic                 found, load;
    entry_t               out_q, out_d;
    logic                 valid_q, valid_d;

    // First non-empty FIFO at or after the round-robin pointer, wrapping.
    always_comb begin
        uext_t idx;
        uext_t nxt;
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            idx = uext_t'(rr_q) + uext_t'(i);
            if (idx >= uext_t'(NUM_UNITS)) idx = idx - uext_t'(NUM_UNITS);
            if (!found && count_q[idx[UW-1:0]] != '0) begin
                found = 1'b1;
                grant = idx[UW-1:0];
            end
        end
        nxt            = uext_t'(grant) + uext_t'(1);
        rr_after_grant = (nxt == uext_t'(NUM_UNITS)) ? '0 : nxt[UW-1:0];
    end

    always_comb begin
        load       = !valid_q || wb.wbReady_i;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        out_d      = out_q;
        valid_d    = valid_q;
        rr_d       = rr_q;
        for (int k = 0; k < NUM_UNITS; k++) begin
            in_entry[k].code  = wb.unitCode_i[k*UNIT_CODE_WIDTH +: UNIT_CODE_WIDTH];
            in_entry[k].en1   = wb.reg1En_i[k];
            in_entry[k].en2   = wb.reg2En_i[k];
            in_entry[k].addr1 = wb.reg1Addr_i[k*REG_WIDTH +: REG_WIDTH];
            in_entry[k].addr2 = wb.reg2Addr_i[k*REG_WIDTH +: REG_WIDTH];
            in_entry[k].val1  = wb.reg1Val_i[k*DATA_WIDTH +: DATA_WIDTH];
            in_entry[k].val2  = wb.reg2Val_i[k*DATA_WIDTH +: DATA_WIDTH];
            not_full[k] = (count_q[k] != CNT_W'(DEPTH));
            push[k] = !flush_i && wb.valid_i[k] && not_full[k]
                      && (wb.reg1En_i[k] || wb.reg2En_i[k]);
            pop[k]  = !flush_i && load && found && (grant == UW'(k));
            if (!flush_i && wb.valid_i[k] && !not_full[k]) overflow_d[k] = 1'b1;
            if (push[k]) begin
                mem_d[k][wr_ptr_q[k]] = in_entry[k];
                wr_ptr_d[k] = wr_ptr_q[k] + PTR_W'(1);
            end
            if (pop[k]) rd_ptr_d[k] = rd_ptr_q[k] + PTR_W'(1);
            if (push[k] && !pop[k])      count_d[k] = count_q[k] + CNT_W'(1);
            else if (pop[k] && !push[k]) count_d[k] = count_q[k] - CNT_W'(1);
            if (flush_i) begin
                count_d[k]  = '0;
                wr_ptr_d[k] = '0;
                rd_ptr_d[k] = '0;
            end
        end
        if (flush_i) begin
            valid_d = 1'b0;
            rr_d    = '0;
        end else if (load) begin
            valid_d = found;
            if (found) begin
                out_d = mem_q[grant][rd_ptr_q[grant]];
                rr_d  = rr_after_grant;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int k = 0; k < NUM_UNITS; k++) begin
                for (int d = 0; d < DEPTH; d++) mem_q[k][d] <= '0;
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                count_q[k]  <= '0;
            end
            overflow_q <= '0;
            out_q      <= '0;
            valid_q    <= 1'b0;
            rr_q       <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
            rr_q       <= rr_d;
        end
    end

    assign wb.ready_o                = not_full;
    assign wb.overflow_o             = overflow_q;
    assign wb.valid_o                = valid_q;
    assign wb.functionalUnitCode_o   = out_q.code;
    assign wb.reg1WritebackEnable_o  = out_q.en1;
    assign wb.reg2WritebackEnable_o  = out_q.en2;
    assign wb.reg1WritebackAddress_o = out_q.addr1;
    assign wb.reg2WritebackAddress_o = out_q.addr2;
    assign wb.reg1WritebackVal_o     = out_q.val1;
    assign wb.reg2WritebackVal_o     = out_q.val2;

endmodule

`default_nettype wire

// File: tb/tb_writeback_merge_arbiter.sv
// ============================================================================
// tb_writeback_merge_arbiter : directed scenario bench for the merge arbiter
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_writeback_merge_arbiter;
    localparam int N  = 4;
    localparam int RW = 5;
    localparam int DW = 64;
    localparam int CW = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    writeback_merge_arbiter_if #(.NUM_UNITS(N), .REG_WIDTH(RW), .DATA_WIDTH(DW),
                                 .UNIT_CODE_WIDTH(CW)) wb ();

    writeback_merge_arbiter #(.NUM_UNITS(N), .DEPTH(4), .REG_WIDTH(RW), .DATA_WIDTH(DW),
                              .UNIT_CODE_WIDTH(CW)) dut (
        .clock_i (clk),
        .reset_i (rst_n),
        .flush_i (flush),
        .wb      (wb)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wb.valid_i    = '0;
        wb.unitCode_i = '0;
        wb.reg1En_i   = '0;
        wb.reg2En_i   = '0;
        wb.reg1Addr_i = '0;
        wb.reg2Addr_i = '0;
        wb.reg1Val_i  = '0;
        wb.reg2Val_i  = '0;
    endtask

    task automatic set_req(input int k, input logic e1, input logic e2,
                           input logic [RW-1:0] a, input logic [DW-1:0] v,
                           input logic [CW-1:0] c);
        wb.valid_i[k]             = 1'b1;
        wb.reg1En_i[k]            = e1;
        wb.reg2En_i[k]            = e2;
        wb.reg1Addr_i[k*RW +: RW] = a;
        wb.reg2Addr_i[k*RW +: RW] = a + 5'd1;
        wb.reg1Val_i[k*DW +: DW]  = v;
        wb.reg2Val_i[k*DW +: DW]  = ~v;
        wb.unitCode_i[k*CW +: CW] = c;
    endtask

    task automatic do_reset();
        clear_inputs();
        flush        = 1'b0;
        wb.wbReady_i = 1'b1;
        rst_n        = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        wb.wbReady_i = 1'b1;
        for (int k = 0; k < N; k++) set_req(k, 1'b1, 1'b0, RW'(k), DW'(k), CW'(k));
        rst_n = 1'b0;
        tick();
        tick();
        tests_run++;
        if (wb.valid_o !== 1'b0) begin
            tests_failed++; $display("FAIL reset_valid: got %b expected 0", wb.valid_o);
        end
        tests_run++;
        if (wb.ready_o !== 4'b1111) begin
            tests_failed++; $display("FAIL reset_ready: got %b expected 1111", wb.ready_o);
        end
        tests_run++;
        if (wb.overflow_o !== 4'b0000 || wb.reg1WritebackVal_o !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_ovf_data: got ovf %b val %h expected 0000 / 0",
                     wb.overflow_o, wb.reg1WritebackVal_o);
        end
        clear_inputs();
        rst_n = 1'b1;
        tick();
        tick();
        tests_run++;
        if (wb.valid_o !== 1'b0 || wb.ready_o !== 4'b1111) begin
            tests_failed++;
            $display("FAIL reset_release: got valid %b ready %b expected 0 / 1111",
                     wb.valid_o, wb.ready_o);
        end
    endtask

    task automatic test_latency();
        do_reset();
        set_req(1, 1'b1, 1'b0, 5'd5, 64'hDEAD, 3'd5);
        tick();
        clear_inputs();
        tests_run++;
        if (wb.valid_o !== 1'b0) begin
            tests_failed++; $display("FAIL lat_early: got valid %b expected 0", wb.valid_o);
        end
        tick();
        tests_run++;
        if (wb.valid_o !== 1'b1 || wb.reg1WritebackAddress_o !== 5'd5 ||
            wb.reg1WritebackVal_o !== 64'hDEAD) begin
            tests_failed++;
            $display("FAIL lat_out: got valid %b addr %0d val %h expected 1 / 5 / dead",
                     wb.valid_o, wb.reg1WritebackAddress_o, wb.reg1WritebackVal_o);
        end
        tests_run++;
        if (wb.reg1WritebackEnable_o !== 1'b1 || wb.reg2WritebackEnable_o !== 1'b0 ||
            wb.functionalUnitCode_o !== 3'd5 || wb.reg2WritebackAddress_o !== 5'd6) begin
            tests_failed++;
            $display("FAIL lat_fields: got en1 %b en2 %b code %0d addr2 %0d expected 1 / 0 / 5 / 6",
                     wb.reg1WritebackEnable_o, wb.reg2WritebackEnable_o,
                     wb.functionalUnitCode_o, wb.reg2WritebackAddress_o);
        end
        tick();
        tests_run++;
        if (wb.valid_o !== 1'b0) begin
            tests_failed++; $display("FAIL lat_drain: got valid %b expected 0", wb.valid_o);
        end
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] exp_v [2];
        do_reset();
        for (int k = 0; k < N; k++) set_req(k, 1'b1, 1'b1, RW'(k + 1), DW'(100 + k), CW'(k));
        tick();
        clear_inputs();
        for (int k = 0; k < N; k++) begin
            tick();
            tests_run++;
            if (wb.valid_o !== 1'b1 || wb.reg1WritebackVal_o !== DW'(100 + k) ||
                wb.functionalUnitCode_o !== CW'(k)) begin
                tests_failed++;
                $display("FAIL rr_order%0d: got valid %b val %0d code %0d expected 1 / %0d / %0d",
                         k, wb.valid_o, wb.reg1WritebackVal_o, wb.functionalUnitCode_o,
                         100 + k, k);
            end
        end
        tick();
        tests_run++;
        if (wb.valid_o !== 1'b0) begin
            tests_failed++; $display("FAIL rr_empty: got valid %b expected 0", wb.valid_o);
        end
        set_req(3, 1'b1, 1'b0, 5'd9, 64'h333, 3'd3);
        set_req(0, 1'b1, 1'b0, 5'd8, 64'h111, 3'd0);
        tick();
        clear_inputs();
        exp_v[0] = 64'h111;
        exp_v[1] = 64'h333;
        for (int j = 0; j < 2; j++) begin
            tick();
            tests_run++;
            if (wb.valid_o !== 1'b1 || wb.reg1WritebackVal_o !== exp_v[j]) begin
                tests_failed++;
                $display("FAIL rr_pair%0d: got valid %b val %h expected 1 / %h",
                         j, wb.valid_o, wb.reg1WritebackVal_o, exp_v[j]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        wb.wbReady_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_req(2, 1'b1, 1'b0, RW'(i + 1), DW'(16 + i), 3'd2);
            tick();
            if (i == 3) begin
                tests_run++;
                if (wb.ready_o[2] !== 1'b1) begin
                    tests_failed++; $display("FAIL bp_ready_pre: got %b expected 1", wb.ready_o[2]);
                end
            end
            if (i == 4) begin
                tests_run++;
                if (wb.ready_o[2] !== 1'b0 || wb.overflow_o[2] !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL bp_full: got ready %b ovf %b expected 0 / 0",
                             wb.ready_o[2], wb.overflow_o[2]);
                end
            end
        end
        clear_inputs();
        tests_run++;
        if (wb.overflow_o !== 4'b0100) begin
            tests_failed++; $display("FAIL bp_overflow: got %b expected 0100", wb.overflow_o);
        end
        tests_run++;
        if (wb.valid_o !== 1'b1 || wb.reg1WritebackVal_o !== 64'd16) begin
            tests_failed++;
            $display("FAIL bp_hold: got valid %b val %0d expected 1 / 16",
                     wb.valid_o, wb.reg1WritebackVal_o);
        end
        wb.wbReady_i = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            tick();
            tests_run++;
            if (wb.valid_o !== 1'b1 || wb.reg1WritebackVal_o !== DW'(16 + j)) begin
                tests_failed++;
                $display("FAIL bp_drain%0d: got valid %b val %0d expected 1 / %0d",
                         j, wb.valid_o, wb.reg1WritebackVal_o, 16 + j);
            end
            if (j == 1) begin
                tests_run++;
                if (wb.ready_o[2] !== 1'b1) begin
                    tests_failed++; $display("FAIL bp_ready_post: got %b expected 1", wb.ready_o[2]);
                end
            end
        end
        tick();
        tests_run++;
        if (wb.valid_o !== 1'b0 || wb.overflow_o[2] !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_end: got valid %b ovf %b expected 0 / 1",
                     wb.valid_o, wb.overflow_o[2]);
        end
    endtask

    task automatic test_null_request();
        do_reset();
        set_req(0, 1'b0, 1'b0, 5'd3, 64'h55, 3'd0);
        tick();
        clear_inputs();
        tests_run++;
        if (wb.ready_o[0] !== 1'b1 || wb.overflow_o[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL null_ready: got ready %b ovf %b expected 1 / 0",
                     wb.ready_o[0], wb.overflow_o[0]);
        end
        tick();
        tests_run++;
        if (wb.valid_o !== 1'b0) begin
            tests_failed++; $display("FAIL null_nooutput: got valid %b expected 0", wb.valid_o);
        end
        set_req(0, 1'b1, 1'b0, 5'd7, 64'h77, 3'd1);
        tick();
        clear_inputs();
        tick();
        tests_run++;
        if (wb.valid_o !== 1'b1 || wb.reg1WritebackVal_o !== 64'h77) begin
            tests_failed++;
            $display("FAIL null_next: got valid %b val %h expected 1 / 77",
                     wb.valid_o, wb.reg1WritebackVal_o);
        end
        tick();
        tests_run++;
        if (wb.valid_o !== 1'b0) begin
            tests_failed++; $display("FAIL null_count: got valid %b expected 0", wb.valid_o);
        end
    endtask

    task automatic test_flush();
        do_reset();
        wb.wbReady_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1'b1, 1'b0, RW'(i), DW'(64 + i), 3'd0);
            tick();
        end
        clear_inputs();
        tests_run++;
        if (wb.valid_o !== 1'b1 || wb.reg1WritebackVal_o !== 64'd64) begin
            tests_failed++;
            $display("FAIL flush_pre: got valid %b val %0d expected 1 / 64",
                     wb.valid_o, wb.reg1WritebackVal_o);
        end
        flush = 1'b1;
        set_req(1, 1'b1, 1'b0, 5'd2, 64'h99, 3'd1);
        tick();
        flush = 1'b0;
        clear_inputs();
        tests_run++;
        if (wb.valid_o !== 1'b0 || wb.ready_o !== 4'b1111) begin
            tests_failed++;
            $display("FAIL flush_state: got valid %b ready %b expected 0 / 1111",
                     wb.valid_o, wb.ready_o);
        end
        wb.wbReady_i = 1'b1;
        tick();
        tests_run++;
        if (wb.valid_o !== 1'b0) begin
            tests_failed++; $display("FAIL flush_empty: got valid %b expected 0", wb.valid_o);
        end
        set_req(1, 1'b1, 1'b0, 5'd1, 64'hA1, 3'd1);
        set_req(0, 1'b1, 1'b0, 5'd0, 64'hA0, 3'd0);
        tick();
        clear_inputs();
        tick();
        tests_run++;
        if (wb.valid_o !== 1'b1 || wb.reg1WritebackVal_o !== 64'hA0) begin
            tests_failed++;
            $display("FAIL flush_rr0: got valid %b val %h expected 1 / a0",
                     wb.valid_o, wb.reg1WritebackVal_o);
        end
        tick();
        tests_run++;
        if (wb.valid_o !== 1'b1 || wb.reg1WritebackVal_o !== 64'hA1) begin
            tests_failed++;
            $display("FAIL flush_rr1: got valid %b val %h expected 1 / a1",
                     wb.valid_o, wb.reg1WritebackVal_o);
        end
    endtask

    initial begin
        clear_inputs();
        wb.wbReady_i = 1'b1;
        test_reset();
        test_latency();
        test_round_robin();
        test_backpressure();
        test_null_request();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
